// File: rtl/reg_wr_arbiter_pkg.sv
// Shared definitions for the register write arbiter.
// - arb_state_e    : arbiter FSM states (IDLE, LOCKED)
// - BURST_W_DEF    : burst counter width for the default MAX_BURST
// - WCW            : width of the accepted-write counter
// - burst_cnt_w()  : burst counter width for a given MAX_BURST
package reg_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int MAX_BURST_DEF = 4;
    localparam int BURST_W_DEF   = $clog2(MAX_BURST_DEF);
    localparam int WCW           = 16;

    // The counter only has to reach MAX_BURST-1.
    function automatic int burst_cnt_w(input int max_burst);
        return $clog2(max_burst);
    endfunction

endpackage

// File: rtl/reg_wr_arbiter_if.sv
// Requester/register bus of the write arbiter.
// master : requester side, drives req_valid/req_lock/req_data
// slave  : arbiter side, drives req_ready and the shared register outputs
//   req_valid[NREQ]    requester i has write data
//   req_lock[NREQ]     requester i wants to keep ownership after its write
//   req_data[NREQ*DW]  requester i data at [i*DW +: DW]
//   req_ready[NREQ]    one-hot-or-zero grant
//   q, q_bar[DW]       shared register and its complement
//   q_owner            index of the last accepted writer
//   wr_count[16]       total accepted writes (wraps)
//   busy               high while a lock is held
interface reg_wr_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [DW-1:0]      q;
    logic [DW-1:0]      q_bar;
    logic [OW-1:0]      q_owner;
    logic [WCW-1:0]     wr_count;
    logic               busy;

    modport master (
        output req_valid, req_lock, req_data,
        input  req_ready, q, q_bar, q_owner, wr_count, busy
    );

    modport slave (
        input  req_valid, req_lock, req_data,
        output req_ready, q, q_bar, q_owner, wr_count, busy
    );

endinterface

// File: rtl/reg_wr_arbiter_rr_pick.sv
// Rotating-priority picker: grants the first set request bit found
// searching upward from ptr_i, wrapping modulo NREQ.
//   req_i  : request vector
//   ptr_i  : index with highest priority
//   gnt_o  : one-hot grant (zero when no request)
//   idx_o  : index of the granted bit (0 when no request)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o
);

    int   pos;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin write arbiter owning a shared DW-bit register.
// Requesters compete through valid/ready; a winner may lock the register
// for a burst of at most MAX_BURST consecutive ownership cycles.
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : slave side of reg_wr_arbiter_if (requests, grant, register)
//
// state  | meaning
// IDLE   | round-robin grant from ptr among valid requesters
// LOCKED | only the lock owner may write; others are held off
module reg_wr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    reg_wr_arbiter_if.slave bus
);

    localparam int PW = $clog2(NREQ);
    localparam int BW = burst_cnt_w(MAX_BURST);

    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_LOCKED = LOCKED;

    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(NREQ - 1);

    logic [0:0]     state_q,    state_d;
    logic [PW-1:0]  ptr_q,      ptr_d;
    logic [BW-1:0]  burst_q,    burst_d;
    logic [DW-1:0]  data_q,     data_d;
    logic [DW-1:0]  data_bar_q, data_bar_d;
    logic [PW-1:0]  owner_q,    owner_d;
    logic [WCW-1:0] wr_cnt_q,   wr_cnt_d;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic [NREQ-1:0] ready;
    logic [PW-1:0]   winner;
    logic            accept;
    logic [DW-1:0]   win_data;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // In LOCKED the last accepted writer is the lock owner, so q_owner
    // doubles as the lock owner register.
    always_comb begin
        ready  = '0;
        winner = owner_q;
        if (state_q == ST_IDLE) begin
            ready  = pick_gnt;
            winner = pick_idx;
        end else begin
            ready[owner_q] = bus.req_valid[owner_q];
        end
        if (!rst) begin
            ready = '0;
        end
    end

    // ready is only ever set on a valid requester, so any bit is an accept.
    assign accept   = |ready;
    assign win_data = bus.req_data[int'(winner) * DW +: DW];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        burst_d    = burst_q;
        data_d     = data_q;
        data_bar_d = data_bar_q;
        owner_d    = owner_q;
        wr_cnt_d   = wr_cnt_q;

        if (accept) begin
            data_d     = win_data;
            data_bar_d = ~win_data;
            owner_d    = winner;
            wr_cnt_d   = wr_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ptr_d = (winner == PTR_LAST) ? '0 : winner + 1'b1;
                    if (bus.req_lock[winner]) begin
                        state_d = ST_LOCKED;
                        burst_d = BW'(1);
                    end
                end
            end
            default: begin
                if (!bus.req_lock[owner_q] || burst_q == BURST_LAST) begin
                    state_d = ST_IDLE;
                    burst_d = '0;
                end else begin
                    burst_d = burst_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            burst_q    <= '0;
            data_q     <= '0;
            data_bar_q <= '1;
            owner_q    <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            burst_q    <= burst_d;
            data_q     <= data_d;
            data_bar_q <= data_bar_d;
            owner_q    <= owner_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.q         = data_q;
    assign bus.q_bar     = data_bar_q;
    assign bus.q_owner   = owner_q;
    assign bus.wr_count  = wr_cnt_q;
    assign bus.busy      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_reg_wr_arbiter.sv
module tb_reg_wr_arbiter;
    import reg_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MB   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    reg_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: ownership is a "lock owner" plus "cycles left".
    int       m_ptr   = 0;
    int       m_lk    = -1;
    int       m_left  = 0;
    int       m_owner = 0;
    int       m_cnt   = 0;
    logic [7:0] m_q   = 8'h00;
    bit       m_known = 0;

    logic [3:0] obs_ready;
    logic       obs_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_ready(input logic r, input logic [3:0] v);
        logic [3:0] g;
        g = 4'b0000;
        if (!r) return g;
        if (m_lk >= 0) begin
            if (v[m_lk]) g[m_lk] = 1'b1;
            return g;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) begin
                g[(m_ptr + k) % NREQ] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic step(input logic r, input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
        logic [3:0] exp_r;
        int w;
        @(negedge clk);
        rst           = r;
        bus.req_valid = v;
        bus.req_lock  = l;
        bus.req_data  = d;
        #1;
        exp_r     = m_ready(r, v);
        obs_ready = bus.req_ready;
        obs_busy  = bus.busy;
        chk("req_ready", {28'd0, bus.req_ready}, {28'd0, exp_r});
        if (m_known) begin
            chk("q",        {24'd0, bus.q},       {24'd0, m_q});
            chk("q_bar",    {24'd0, bus.q_bar},   {24'd0, ~m_q});
            chk("q_owner",  {30'd0, bus.q_owner}, m_owner);
            chk("wr_count", {16'd0, bus.wr_count}, m_cnt);
            chk("busy",     {31'd0, bus.busy},    {31'd0, (m_lk >= 0)});
        end
        @(posedge clk);
        if (!r) begin
            m_q = 8'h00; m_owner = 0; m_cnt = 0; m_ptr = 0; m_lk = -1; m_left = 0;
            m_known = 1;
        end else begin
            w = -1;
            for (int i = 0; i < NREQ; i++) if (exp_r[i]) w = i;
            if (w >= 0) begin
                m_q     = d[w*DW +: DW];
                m_owner = w;
                m_cnt   = (m_cnt + 1) % 65536;
            end
            if (m_lk < 0) begin
                if (w >= 0) begin
                    m_ptr = (w + 1) % NREQ;
                    if (l[w]) begin
                        m_lk   = w;
                        m_left = MB - 1;
                    end
                end
            end else begin
                m_left--;
                if (!l[m_lk] || m_left == 0) m_lk = -1;
            end
        end
        #1;
    endtask

    logic [3:0] rr_exp [5];
    int busy_n;

    initial begin
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_data  = '0;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset with every requester valid: no grant.
        step(1'b0, 4'hF, 4'h0, 32'h0);
        chk("rst_ready0", {28'd0, obs_ready}, 32'h0);
        step(1'b0, 4'hF, 4'h0, 32'h0);
        chk("rst_ready1", {28'd0, obs_ready}, 32'h0);
        chk("rst_q",      {24'd0, bus.q},     32'h00);
        chk("rst_q_bar",  {24'd0, bus.q_bar}, 32'hFF);
        chk("rst_wr_cnt", {16'd0, bus.wr_count}, 32'h0);
        chk("rst_busy",   {31'd0, bus.busy},  32'h0);

        // Single write from requester 1.
        step(1'b1, 4'b0010, 4'h0, 32'h0000_A500);
        chk("single_ready", {28'd0, obs_ready}, 32'b0010);
        chk("single_q",     {24'd0, bus.q},     32'hA5);
        chk("single_q_bar", {24'd0, bus.q_bar}, 32'h5A);
        chk("single_owner", {30'd0, bus.q_owner}, 32'd1);
        chk("single_cnt",   {16'd0, bus.wr_count}, 32'd1);

        // Round-robin from ptr=0.
        step(1'b0, 4'h0, 4'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'hF, 4'h0, $urandom);
            chk($sformatf("rr_grant%0d", i), {28'd0, obs_ready}, {28'd0, rr_exp[i]});
        end
        chk("rr_cnt", {16'd0, bus.wr_count}, 32'd5);

        // Full locked burst by requester 2 from ptr=2.
        step(1'b0, 4'h0, 4'h0, 32'h0);
        step(1'b1, 4'b0010, 4'h0, 32'h0);
        busy_n = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'b0101, 4'b0100, $urandom);
            chk($sformatf("burst_grant%0d", i), {28'd0, obs_ready}, 32'b0100);
            if (obs_busy) busy_n++;
        end
        step(1'b1, 4'b0101, 4'b0100, $urandom);
        chk("burst_busy_cycles", busy_n, 32'd3);
        chk("burst_next_grant", {28'd0, obs_ready}, 32'b0001);
        chk("burst_next_busy",  {31'd0, obs_busy},  32'd0);

        // Early unlock in the 2nd LOCKED cycle.
        step(1'b0, 4'h0, 4'h0, 32'h0);
        step(1'b1, 4'b0010, 4'h0, 32'h0);
        step(1'b1, 4'b1100, 4'b0100, $urandom);
        step(1'b1, 4'b1100, 4'b0100, $urandom);
        step(1'b1, 4'b1100, 4'b0000, $urandom);
        chk("unlock_last_grant", {28'd0, obs_ready}, 32'b0100);
        step(1'b1, 4'b1100, 4'b0000, $urandom);
        chk("unlock_next_grant", {28'd0, obs_ready}, 32'b1000);
        chk("unlock_busy",       {31'd0, obs_busy},  32'd0);

        // Reset in LOCKED cycle 2.
        step(1'b0, 4'h0, 4'h0, 32'h0);
        step(1'b1, 4'b0100, 4'b0100, 32'h0033_0000);
        step(1'b1, 4'b0100, 4'b0100, 32'h0044_0000);
        step(1'b0, 4'b0100, 4'b0100, 32'h0055_0000);
        chk("midrst_ready", {28'd0, obs_ready}, 32'h0);
        chk("midrst_busy",  {31'd0, bus.busy},  32'd0);
        chk("midrst_q",     {24'd0, bus.q},     32'h00);
        chk("midrst_cnt",   {16'd0, bus.wr_count}, 32'd0);
        step(1'b1, 4'hF, 4'h0, $urandom);
        chk("midrst_ptr0", {28'd0, obs_ready}, 32'b0001);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] lk;
            lk = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            step(($urandom_range(0, 59) != 0), 4'($urandom), lk, $urandom);
        end

        // wr_count wraps after 65536 accepts.
        step(1'b0, 4'h0, 4'h0, 32'h0);
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 4'($urandom_range(1, 15)), 4'h0, $urandom);
        end
        chk("wrap_cnt", {16'd0, bus.wr_count}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
